// File: rtl/bcd_dial_counter_if.sv
// Control/status bundle for the BCD dial counter: step, clear and load controls in,
// BCD position and event pulses out.
interface bcd_dial_counter_if #(
  parameter int DIGITS = 2
);
  logic                  up;
  logic                  cnten1;
  logic                  cnten2;
  logic                  clrCount;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   bcd;
  logic                  wrap;
  logic                  dir_chg;
  logic                  load_err;
  logic                  at_zero;

  modport master (
    output up, cnten1, cnten2, clrCount, load, load_val,
    input  bcd, wrap, dir_chg, load_err, at_zero
  );

  modport slave (
    input  up, cnten1, cnten2, clrCount, load, load_val,
    output bcd, wrap, dir_chg, load_err, at_zero
  );
endinterface

// File: rtl/bcd_dial_counter.sv
// Wrapping BCD dial position counter with validated load, wrap and direction-change pulses.
// Priority each cycle: clear, then load, then step.
module bcd_dial_counter #(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 31
) (
  input  logic              clk,
  input  logic              rst,
  bcd_dial_counter_if.slave dial
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // With valid digits, BCD ordering matches plain binary ordering, so one compare suffices.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  logic [W-1:0] cnt;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         load_ok;
  logic         step;
  logic         last_up;
  logic         dir_valid;
  logic         wrap_q;
  logic         dir_chg_q;
  logic         load_err_q;

  always_comb begin
    logic carry;
    inc_val = cnt;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic borrow;
    dec_val = cnt;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (cnt[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_ok = (dial.load_val <= MAX_BCD);
    for (int i = 0; i < DIGITS; i++) begin
      if (dial.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  assign step = !dial.cnten1 && !dial.cnten2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      last_up    <= 1'b1;
      dir_valid  <= 1'b0;
      wrap_q     <= 1'b0;
      dir_chg_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      dir_chg_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (dial.clrCount) begin
        cnt       <= '0;
        dir_valid <= 1'b0;
      end else if (dial.load) begin
        if (load_ok) begin
          cnt       <= dial.load_val;
          dir_valid <= 1'b0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (step) begin
        if (dial.up) begin
          if (cnt == MAX_BCD) begin
            cnt    <= '0;
            wrap_q <= 1'b1;
          end else begin
            cnt <= inc_val;
          end
        end else begin
          if (cnt == '0) begin
            cnt    <= MAX_BCD;
            wrap_q <= 1'b1;
          end else begin
            cnt <= dec_val;
          end
        end
        dir_chg_q <= dir_valid && (dial.up != last_up);
        last_up   <= dial.up;
        dir_valid <= 1'b1;
      end
    end
  end

  assign dial.bcd      = cnt;
  assign dial.wrap     = wrap_q;
  assign dial.dir_chg  = dir_chg_q;
  assign dial.load_err = load_err_q;
  assign dial.at_zero  = (cnt == '0);

endmodule
